sb_tx_serializer: RTL and testbench
===================================

Name: sb_tx_serializer

Overview:
- Sideband transmit serializer. It is the far end of the SB TX message port that the LTSM state blocks drive (message, data bus, valid, send-next).
- Each accepted request becomes a 64-UI header packet, optionally followed by a 64-UI data packet. Packets go out LSB-first on the SB data pin, with a qualified clock indication and the mandatory idle gap between packets.
- Sits in logphy between the LTSM sideband message mux and the SB TX pads; runs entirely in the 800 MHz sideband domain.

Parameters:
- PKT_UI, 64, bits per packet (header or data).
- GAP_UI, 32, minimum low, clock-idle UI between consecutive packets.
- GAP_CNT_W, 6, width of the shared UI counter; must hold max(PKT_UI, GAP_UI)-1.

Ports:
- clk_800MHz  in  1  sideband bit clock, one UI per cycle.
- reset  in  1  synchronous, active-high reset.
- enable_i  in  1  block enable; low stops new acceptances only.
- SB_TX_msg_i  in  SB_msg_t  message identifier to encode.
- SB_TX_dataBus_i  in  64  payload, used only when the message carries data.
- SB_TX_msg_valid_i  in  1  request valid.
- SB_TX_msg_sendNextFlag_o  out  1  ready; transfer occurs when valid and ready are both high.
- SB_clkPin_TX_o  out  1  registered clock-active qualifier. The pad cell gates clk_800MHz with it.
- SB_dataPin_TX_o  out  1  registered serial data.
- busy_o  out  1  high in any state other than IDLE.
- pkt_sent_o  out  1  one-cycle pulse on the last UI of the final packet of a message.

Behaviour:
- Reset (synchronous, active-high): state IDLE; all outputs 0; shift register, UI counter and has_data flag cleared. Reset mid-packet aborts immediately: the pins drop to 0 on the next edge and no partial completion is reported.
- SB_TX_msg_sendNextFlag_o = (state==IDLE) & enable_i & ~reset. It is combinational from registered state.
- Accept in IDLE when valid & ready:
  - Latch hdr = sb_build_header(SB_TX_msg_i).
  - Latch data = SB_TX_dataBus_i.
  - Latch has_data = sb_msg_has_data(SB_TX_msg_i).
  - Next state HDR, counter = 0.
- Inputs are don't-care outside the accept cycle.
- FSM:
  - IDLE -> HDR on accept.
  - HDR: for PKT_UI cycles, SB_dataPin_TX_o = shift[0] and SB_clkPin_TX_o = 1; shift right once per cycle. At counter==PKT_UI-1, go to GAP1 if has_data, else GAP2.
  - GAP1: GAP_UI cycles with both pins 0; load data into the shift register; then DATA.
  - DATA: like HDR but shifting the data word; then GAP2.
  - GAP2: GAP_UI cycles with both pins 0; then IDLE.
- Latency: first header bit appears on the pin in the cycle after the accept edge.
- Gap timing: the IDLE cycle after GAP2 adds at least 1 UI, so the inter-message gap is at least GAP_UI+1.
- pkt_sent_o pulses on the last HDR cycle if has_data=0, or on the last DATA cycle if has_data=1.
- Counter: GAP_CNT_W bits. It resets to 0 on every state change and never wraps inside a state.
- enable_i deasserted mid-message: the current message completes, including GAP2; no further acceptance follows.
- Valid held high continuously: back-to-back messages are accepted one per IDLE visit, with no loss or duplication.

Optional Feature:
- Macro: SB_TX_PARITY_EN.
- Defined:
  - Header bit 62 (CP) is overwritten with the even parity (XOR) of header bits [61:0].
  - Header bit 63 (DP) is overwritten with the XOR of the 64 data bits if has_data, else 0.
  - Both are computed combinationally at accept and latched with the header.
- Undefined: bits 62/63 are sent exactly as sb_build_header returns them.

Decomposition:
- SB_codex_pkg (existing) holds:
  - SB_msg_t;
  - function sb_build_header(SB_msg_t) returning logic[63:0] (opcode, msgcode, msginfo, srcid/dstid fields);
  - function sb_msg_has_data(SB_msg_t);
  - localparams SB_PKT_UI=64 and SB_GAP_UI=32;
  - enum sb_tx_state_t {IDLE, HDR, GAP1, DATA, GAP2}.
- One natural sub-module, sb_tx_shifter: a 64-bit load/shift register with LSB-out and a UI counter. The FSM stays in the parent.

Test Plan:
- Reset behaviour: reset held 5 cycles mid-HDR at UI 20 -> pins 0 on the next edge; state IDLE; pkt_sent_o never pulses; ready=1 the following cycle with enable_i=1.
- No-data message: accept one no-data message whose header = 64'hA5A5_0000_1234_5678 -> data pin shows bits 0..63 LSB-first over 64 cycles starting 1 cycle after accept; clk pin high exactly those 64 cycles; pkt_sent_o on cycle 64; pins then low for at least 33 cycles before the next header.
- Data message: accept a data message with data=64'hDEAD_BEEF_0123_4567 -> 64 header UI, then 32 low UI, then 64 data UI LSB-first; pkt_sent_o only on the last data UI; busy_o high for 192 cycles.
- Back-to-back: valid held high with 3 queued no-data messages -> exactly 3 headers; each acceptance spaced 64+32+1=97 cycles apart; ready high only 1 cycle per message.
- Enable drop: enable_i dropped at DATA UI 10 -> message completes; ready stays 0 afterwards; re-raising enable_i -> next accept works.
- Parity (SB_TX_PARITY_EN): header [61:0] with odd popcount and data 64'h1 -> transmitted bit 62=1 and bit 63=1. Without the macro, bits 62/63 are sent unchanged.

Source files
------------

// File: rtl/SB_codex_pkg.sv
// -----------------------------------------------------------------------------
// SB_codex_pkg
// Shared sideband codec definitions used by the SB TX serializer:
//   - SB_msg_t        : sideband message identifiers
//   - sb_tx_state_t   : serializer FSM states
//   - sb_build_header : message -> 64-bit header packet
//   - sb_msg_has_data : message carries a 64-bit data packet
//   - SB_PKT_UI / SB_GAP_UI : packet length and minimum idle gap, in UI
// -----------------------------------------------------------------------------
package SB_codex_pkg;

    localparam int SB_PKT_UI = 64;
    localparam int SB_GAP_UI = 32;

    // Header opcodes: message without data / message with 64-bit data
    localparam logic [4:0] SB_OP_NODATA = 5'b10010;
    localparam logic [4:0] SB_OP_DATA   = 5'b11011;

    // Fixed source/destination identifiers for logphy-originated messages
    localparam logic [2:0] SB_SRCID = 3'b001;
    localparam logic [2:0] SB_DSTID = 3'b101;

    typedef enum logic [3:0] {
        SB_MSG_NONE          = 4'd0,
        SB_OUT_OF_RESET      = 4'd1,
        SB_DONE_REQ          = 4'd2,
        SB_DONE_RESP         = 4'd3,
        SB_MBINIT_PARAM_REQ  = 4'd4,
        SB_MBINIT_PARAM_RESP = 4'd5,
        SB_TRAINERROR_REQ    = 4'd6,
        SB_REPAIR_RESULT     = 4'd7
    } SB_msg_t;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HDR  = 3'd1,
        GAP1 = 3'd2,
        DATA = 3'd3,
        GAP2 = 3'd4
    } sb_tx_state_t;

    function automatic logic sb_msg_has_data(input SB_msg_t msg);
        logic has_data;
        case (msg)
            SB_MBINIT_PARAM_REQ,
            SB_MBINIT_PARAM_RESP,
            SB_REPAIR_RESULT:     has_data = 1'b1;
            default:              has_data = 1'b0;
        endcase
        return has_data;
    endfunction

    // Header layout:
    //   [4:0] opcode, [21:14] msgcode, [39:32] msgsubcode,
    //   [58:56] srcid, [61:59] dstid, [62] CP, [63] DP (returned as 0)
    function automatic logic [63:0] sb_build_header(input SB_msg_t msg);
        logic [7:0]  code;
        logic [7:0]  sub;
        logic [63:0] hdr;
        code = 8'h00;
        sub  = 8'h00;
        case (msg)
            SB_OUT_OF_RESET:      begin code = 8'h91; sub = 8'h00; end
            SB_DONE_REQ:          begin code = 8'h95; sub = 8'h01; end
            SB_DONE_RESP:         begin code = 8'h9A; sub = 8'h01; end
            SB_MBINIT_PARAM_REQ:  begin code = 8'hA5; sub = 8'h00; end
            SB_MBINIT_PARAM_RESP: begin code = 8'hAA; sub = 8'h00; end
            SB_TRAINERROR_REQ:    begin code = 8'h95; sub = 8'h0F; end
            SB_REPAIR_RESULT:     begin code = 8'hAA; sub = 8'h07; end
            default:              ;
        endcase
        hdr        = '0;
        hdr[4:0]   = sb_msg_has_data(msg) ? SB_OP_DATA : SB_OP_NODATA;
        hdr[21:14] = code;
        hdr[39:32] = sub;
        hdr[58:56] = SB_SRCID;
        hdr[61:59] = SB_DSTID;
        return hdr;
    endfunction

endpackage

// File: rtl/sb_tx_shifter.sv
// -----------------------------------------------------------------------------
// sb_tx_shifter
// Packet shift register (parallel load, shift right, LSB out) plus the shared
// UI counter used by the serializer FSM.
//
// Ports:
//   clk_i        in   bit clock
//   reset_i      in   synchronous active-high reset
//   load_i       in   load load_val_i into the shift register (wins over shift)
//   load_val_i   in   WIDTH-bit packet to load
//   shift_i      in   shift right by one
//   cnt_clr_i    in   clear the UI counter (wins over increment)
//   cnt_inc_i    in   increment the UI counter
//   next_bit_o   out  LSB the register will hold after this edge
//   cnt_o        out  current UI count
// -----------------------------------------------------------------------------
module sb_tx_shifter #(
    parameter int WIDTH = 64,
    parameter int CNT_W = 6
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             shift_i,
    input  logic             cnt_clr_i,
    input  logic             cnt_inc_i,
    output logic             next_bit_o,
    output logic [CNT_W-1:0] cnt_o
);

    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        shift_d = shift_q;
        if (load_i) begin
            shift_d = load_val_i;
        end else if (shift_i) begin
            shift_d = {1'b0, shift_q[WIDTH-1:1]};
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr_i) begin
            cnt_d = '0;
        end else if (cnt_inc_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

    // Looking at the post-edge LSB lets the parent register the pin so it is
    // aligned with the state/counter it belongs to.
    assign next_bit_o = shift_d[0];
    assign cnt_o      = cnt_q;

endmodule

// File: rtl/sb_tx_serializer.sv
// -----------------------------------------------------------------------------
// sb_tx_serializer
// Sideband TX serializer. Each accepted request is sent as a 64-UI header
// packet, optionally followed by a 64-UI data packet, LSB-first, with a
// clock-qualifier pin and a low, clock-idle gap after every packet.
//
// Build option: define SB_TX_PARITY_EN to overwrite header bit 62 (CP) with
// the XOR of header bits [61:0] and bit 63 (DP) with the XOR of the data word
// (0 for messages without data). Without it, bits 62/63 are sent as built.
//
// Ports:
//   clk_800MHz                in   sideband bit clock, one UI per cycle
//   reset                     in   synchronous active-high reset
//   enable_i                  in   block enable, gates new acceptances only
//   SB_TX_msg_i               in   message identifier
//   SB_TX_dataBus_i           in   64-bit payload for data-carrying messages
//   SB_TX_msg_valid_i         in   request valid
//   SB_TX_msg_sendNextFlag_o  out  ready (IDLE & enable & ~reset)
//   SB_clkPin_TX_o            out  registered clock-active qualifier
//   SB_dataPin_TX_o           out  registered serial data
//   busy_o                    out  FSM not in IDLE
//   pkt_sent_o                out  pulse on the last UI of a message
//
// States:
//   IDLE | waiting for valid & ready
//   HDR  | shifting out the header packet
//   GAP1 | idle gap between header and data packets
//   DATA | shifting out the data packet
//   GAP2 | idle gap closing the message
// -----------------------------------------------------------------------------
module sb_tx_serializer
    import SB_codex_pkg::*;
#(
    parameter int PKT_UI    = SB_PKT_UI,
    parameter int GAP_UI    = SB_GAP_UI,
    parameter int GAP_CNT_W = 6
) (
    input  logic        clk_800MHz,
    input  logic        reset,
    input  logic        enable_i,
    input  SB_msg_t     SB_TX_msg_i,
    input  logic [63:0] SB_TX_dataBus_i,
    input  logic        SB_TX_msg_valid_i,
    output logic        SB_TX_msg_sendNextFlag_o,
    output logic        SB_clkPin_TX_o,
    output logic        SB_dataPin_TX_o,
    output logic        busy_o,
    output logic        pkt_sent_o
);

    localparam logic [GAP_CNT_W-1:0] PKT_LAST = GAP_CNT_W'(PKT_UI - 1);
    localparam logic [GAP_CNT_W-1:0] GAP_LAST = GAP_CNT_W'(GAP_UI - 1);

    sb_tx_state_t   state_q, state_d;
    logic           has_data_q, has_data_d;
    logic [63:0]    data_q, data_d;
    logic           clk_pin_q, clk_pin_d;
    logic           data_pin_q, data_pin_d;

    logic [63:0]    hdr_raw, hdr_w;
    logic           msg_has_data;
    logic           accept;

    logic           load, shift, cnt_clr, cnt_inc;
    logic [63:0]    load_val;
    logic           next_bit;
    logic [GAP_CNT_W-1:0] cnt;
    logic           on_wire_d;

    always_comb begin
        hdr_raw      = sb_build_header(SB_TX_msg_i);
        msg_has_data = sb_msg_has_data(SB_TX_msg_i);
        hdr_w        = hdr_raw;
`ifdef SB_TX_PARITY_EN
        hdr_w[62]    = ^hdr_raw[61:0];
        hdr_w[63]    = msg_has_data ? ^SB_TX_dataBus_i : 1'b0;
`endif
    end

    assign SB_TX_msg_sendNextFlag_o = (state_q == IDLE) & enable_i & ~reset;
    assign accept = SB_TX_msg_sendNextFlag_o & SB_TX_msg_valid_i;

    always_comb begin
        state_d    = state_q;
        has_data_d = has_data_q;
        data_d     = data_q;
        load       = 1'b0;
        load_val   = hdr_w;
        shift      = 1'b0;
        cnt_clr    = 1'b0;
        cnt_inc    = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d    = HDR;
                    has_data_d = msg_has_data;
                    data_d     = SB_TX_dataBus_i;
                    load       = 1'b1;
                    load_val   = hdr_w;
                    cnt_clr    = 1'b1;
                end
            end
            HDR: begin
                shift = 1'b1;
                if (cnt == PKT_LAST) begin
                    state_d = has_data_q ? GAP1 : GAP2;
                    cnt_clr = 1'b1;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            GAP1: begin
                if (cnt == GAP_LAST) begin
                    state_d  = DATA;
                    load     = 1'b1;
                    load_val = data_q;
                    cnt_clr  = 1'b1;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            DATA: begin
                shift = 1'b1;
                if (cnt == PKT_LAST) begin
                    state_d = GAP2;
                    cnt_clr = 1'b1;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            GAP2: begin
                if (cnt == GAP_LAST) begin
                    state_d = IDLE;
                    cnt_clr = 1'b1;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_clr = 1'b1;
            end
        endcase

        // Pins are registered from the next state so they line up with the
        // state and UI count they describe.
        on_wire_d  = (state_d == HDR) || (state_d == DATA);
        clk_pin_d  = on_wire_d;
        data_pin_d = on_wire_d & next_bit;
    end

    sb_tx_shifter #(
        .WIDTH (PKT_UI),
        .CNT_W (GAP_CNT_W)
    ) u_shifter (
        .clk_i      (clk_800MHz),
        .reset_i    (reset),
        .load_i     (load),
        .load_val_i (load_val),
        .shift_i    (shift),
        .cnt_clr_i  (cnt_clr),
        .cnt_inc_i  (cnt_inc),
        .next_bit_o (next_bit),
        .cnt_o      (cnt)
    );

    always_ff @(posedge clk_800MHz) begin
        if (reset) begin
            state_q    <= IDLE;
            has_data_q <= 1'b0;
            data_q     <= '0;
            clk_pin_q  <= 1'b0;
            data_pin_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            has_data_q <= has_data_d;
            data_q     <= data_d;
            clk_pin_q  <= clk_pin_d;
            data_pin_q <= data_pin_d;
        end
    end

    assign SB_clkPin_TX_o  = clk_pin_q;
    assign SB_dataPin_TX_o = data_pin_q;
    assign busy_o          = (state_q != IDLE);
    assign pkt_sent_o      = (cnt == PKT_LAST) &
                             (((state_q == HDR) & ~has_data_q) | (state_q == DATA));

endmodule

// File: tb/tb_sb_tx_serializer.sv
module tb_sb_tx_serializer;
    import SB_codex_pkg::*;

    logic        clk = 1'b0;
    logic        reset, enable, valid;
    SB_msg_t     msg;
    logic [63:0] data;
    logic        ready, clk_pin, data_pin, busy, sent;

    always #5 clk = ~clk;

    sb_tx_serializer dut (
        .clk_800MHz               (clk),
        .reset                    (reset),
        .enable_i                 (enable),
        .SB_TX_msg_i              (msg),
        .SB_TX_dataBus_i          (data),
        .SB_TX_msg_valid_i        (valid),
        .SB_TX_msg_sendNextFlag_o (ready),
        .SB_clkPin_TX_o           (clk_pin),
        .SB_dataPin_TX_o          (data_pin),
        .busy_o                   (busy),
        .pkt_sent_o               (sent)
    );

    // Expected per-UI pin activity, one entry per cycle the block is busy.
    typedef struct packed {
        logic pin;
        logic clkq;
        logic sent;
    } ui_t;
    ui_t q[$];

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    logic        nx_reset, nx_enable, nx_valid;
    SB_msg_t     nx_msg;
    logic [63:0] nx_data;

    // observation counters for directed scenarios
    logic [127:0] cap;
    int cap_n, busy_n, sent_n, sent_at, acc_n, ready_n;
    int acc_cyc[0:7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [63:0] model_header(input SB_msg_t m, input logic [63:0] d);
        logic [63:0] h;
        h = sb_build_header(m);
`ifdef SB_TX_PARITY_EN
        h[62] = ^h[61:0];
        h[63] = sb_msg_has_data(m) ? ^d : 1'b0;
`endif
        return h;
    endfunction

    function automatic ui_t mk(input logic p, input logic c, input logic s);
        ui_t u;
        u.pin  = p;
        u.clkq = c;
        u.sent = s;
        return u;
    endfunction

    // A message is: header packet, [gap, data packet], closing gap.
    task automatic schedule(input SB_msg_t m, input logic [63:0] d);
        logic [63:0] h;
        logic        hd;
        h  = model_header(m, d);
        hd = sb_msg_has_data(m);
        for (int i = 0; i < SB_PKT_UI; i++) q.push_back(mk(h[i], 1'b1, !hd && (i == SB_PKT_UI - 1)));
        if (hd) begin
            for (int i = 0; i < SB_GAP_UI; i++) q.push_back(mk(1'b0, 1'b0, 1'b0));
            for (int i = 0; i < SB_PKT_UI; i++) q.push_back(mk(d[i], 1'b1, i == SB_PKT_UI - 1));
        end
        for (int i = 0; i < SB_GAP_UI; i++) q.push_back(mk(1'b0, 1'b0, 1'b0));
    endtask

    task automatic clear_obs();
        cap = '0; cap_n = 0; busy_n = 0; sent_n = 0; sent_at = -1; acc_n = 0; ready_n = 0;
        for (int i = 0; i < 8; i++) acc_cyc[i] = 0;
    endtask

    // One clock: advance the model with the inputs seen at the edge, apply the
    // next inputs, then compare every output against the model.
    task automatic step();
        ui_t e;
        @(posedge clk);
        cyc++;
        if (reset) q.delete();
        else if (q.size() == 0) begin
            if (enable && valid) schedule(msg, data);
        end else void'(q.pop_front());
        #1;
        reset  = nx_reset;
        enable = nx_enable;
        valid  = nx_valid;
        msg    = nx_msg;
        data   = nx_data;
        #1;
        e = (q.size() > 0) ? q[0] : '0;
        chk("busy",     64'(busy),     64'(q.size() > 0));
        chk("clk_pin",  64'(clk_pin),  64'(e.clkq));
        chk("data_pin", 64'(data_pin), 64'(e.pin));
        chk("pkt_sent", 64'(sent),     64'(e.sent));
        chk("ready",    64'(ready),    64'((q.size() == 0) && enable && !reset));
        if (clk_pin) begin
            if (cap_n < 128) cap[cap_n] = data_pin;
            cap_n++;
        end
        if (busy) busy_n++;
        if (sent) begin sent_n++; sent_at = cap_n; end
        if (ready && valid) begin
            if (acc_n < 8) acc_cyc[acc_n] = cyc;
            acc_n++;
        end
        if (ready) ready_n++;
    endtask

    SB_msg_t bb_msgs[0:2];
    logic [63:0] exp_hdr;

    initial begin
        reset = 1'b1; enable = 1'b1; valid = 1'b0; msg = SB_MSG_NONE; data = '0;
        nx_reset = 1'b1; nx_enable = 1'b1; nx_valid = 1'b0; nx_msg = SB_MSG_NONE; nx_data = '0;
        clear_obs();

        // reset
        repeat (5) step();
        chk("ready_in_reset", 64'(ready), 64'(0));
        nx_reset = 1'b0;
        step();
        chk("ready_after_reset", 64'(ready), 64'(1));

        // no-data message
        clear_obs();
        nx_valid = 1'b1; nx_msg = SB_DONE_REQ; nx_data = {$urandom, $urandom};
        step();
        nx_valid = 1'b0;
        repeat (140) step();
        chk("nodata_hdr",    cap[63:0], 64'h2900_0001_0025_4012);
        chk("nodata_ui",     64'(cap_n),   64'(64));
        chk("nodata_busy",   64'(busy_n),  64'(96));
        chk("nodata_sent",   64'(sent_n),  64'(1));
        chk("nodata_sentat", 64'(sent_at), 64'(64));

        // data message
        clear_obs();
        nx_valid = 1'b1; nx_msg = SB_MBINIT_PARAM_REQ; nx_data = 64'hDEAD_BEEF_0123_4567;
        step();
        nx_valid = 1'b0;
        repeat (220) step();
`ifdef SB_TX_PARITY_EN
        exp_hdr = 64'h6900_0000_0029_401B;
`else
        exp_hdr = 64'h2900_0000_0029_401B;
`endif
        chk("data_hdr",    cap[63:0],   exp_hdr);
        chk("data_word",   cap[127:64], 64'hDEAD_BEEF_0123_4567);
        chk("data_ui",     64'(cap_n),   64'(128));
        chk("data_busy",   64'(busy_n),  64'(192));
        chk("data_sent",   64'(sent_n),  64'(1));
        chk("data_sentat", 64'(sent_at), 64'(128));

        // parity bits: header [61:0] has odd popcount, data = 1
        clear_obs();
        nx_valid = 1'b1; nx_msg = SB_MBINIT_PARAM_REQ; nx_data = 64'h1;
        step();
        nx_valid = 1'b0;
        repeat (220) step();
`ifdef SB_TX_PARITY_EN
        chk("parity_bits", 64'(cap[63:62]), 64'(2'b11));
`else
        chk("parity_bits", 64'(cap[63:62]), 64'(2'b00));
`endif

        // reset in the middle of a header
        clear_obs();
        nx_valid = 1'b1; nx_msg = SB_OUT_OF_RESET; nx_data = '0;
        step();
        nx_valid = 1'b0;
        repeat (21) step();
        nx_reset = 1'b1;
        repeat (5) step();
        nx_reset = 1'b0;
        step();
        chk("rst_mid_sent",  64'(sent_n), 64'(0));
        chk("rst_mid_ui",    64'(cap_n),  64'(22));
        chk("rst_mid_ready", 64'(ready),  64'(1));
        repeat (3) step();

        // back-to-back with valid held high
        clear_obs();
        bb_msgs[0] = SB_DONE_REQ; bb_msgs[1] = SB_DONE_RESP; bb_msgs[2] = SB_TRAINERROR_REQ;
        nx_valid = 1'b1;
        for (int i = 0; i < 400 && acc_n < 3; i++) begin
            nx_msg = bb_msgs[acc_n];
            step();
        end
        nx_valid = 1'b0;
        repeat (110) step();
        chk("b2b_accepts", 64'(acc_n),                   64'(3));
        chk("b2b_gap01",   64'(acc_cyc[1] - acc_cyc[0]), 64'(97));
        chk("b2b_gap12",   64'(acc_cyc[2] - acc_cyc[1]), 64'(97));
        chk("b2b_ui",      64'(cap_n),                   64'(192));
        chk("b2b_sent",    64'(sent_n),                  64'(3));

        // enable dropped at DATA UI 10, valid kept high
        clear_obs();
        nx_valid = 1'b1; nx_msg = SB_MBINIT_PARAM_RESP; nx_data = {$urandom, $urandom};
        step();
        nx_msg = SB_DONE_RESP;
        repeat (107) step();
        nx_enable = 1'b0;
        step();
        ready_n = 0;
        repeat (150) step();
        chk("en_drop_ready", 64'(ready_n), 64'(0));
        chk("en_drop_acc",   64'(acc_n),   64'(1));
        chk("en_drop_sent",  64'(sent_n),  64'(1));
        chk("en_drop_ui",    64'(cap_n),   64'(128));
        nx_enable = 1'b1;
        for (int i = 0; i < 5 && acc_n < 2; i++) step();
        chk("en_reraise_acc", 64'(acc_n), 64'(2));
        nx_valid = 1'b0;
        repeat (120) step();

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            nx_valid  = ($urandom_range(0, 3) == 0);
            nx_enable = ($urandom_range(0, 19) != 0);
            nx_reset  = ($urandom_range(0, 599) == 0);
            nx_msg    = SB_msg_t'(4'($urandom_range(0, 7)));
            nx_data   = {$urandom, $urandom};
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
